// File: rtl/pipeline_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipeline_sequencer: RV32I 5-stage hazard/flush/freeze sequencer.           |
// | Optional macro FORWARDING_EN (load-use only hazards).  Revision: 1.0       |
// +----------------------------------------------------------------------------+
module pipeline_sequencer #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CW          = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [4:0]    id_rs1,
  input  logic [4:0]    id_rs2,
  input  logic          id_uses_rs1,
  input  logic          id_uses_rs2,
  input  logic [4:0]    id_rd,
  input  logic          id_write_reg,
  input  logic          id_read_mem,
  input  logic          ex_redirect,
  input  logic          mem_req,
  input  logic          mem_ready,
  output logic          pc_en,
  output logic          if_id_en,
  output logic          if_id_flush,
  output logic          id_ex_en,
  output logic          id_ex_flush,
  output logic          ex_mem_en,
  output logic          mem_wb_en,
  output logic          mem_busy,
  output logic          mem_error,
  output logic [CW-1:0] stall_count
);

  localparam int            c_tw        = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [c_tw-1:0] c_wait_last = c_tw'(MEM_TIMEOUT - 1);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       write_reg;
    logic       read_mem;
  } sb_entry_t;

  typedef enum logic [0:0] {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mem_state_t;

  mem_state_t      r_mstate;
  mem_state_t      w_mstate_nxt;
  logic [c_tw-1:0] r_wait_cnt;
  logic            r_mem_error;
  logic [CW-1:0]   r_stall_count;
  sb_entry_t       r_ex;
  sb_entry_t       r_mem;

  logic w_timeout_hit;
  logic w_fz;
  logic w_hz;
  logic w_stall;
  logic w_ex_hit;

  function automatic logic f_match(input logic used, input logic [4:0] src, input sb_entry_t e);
    return used && e.valid && e.write_reg && (e.rd == src) && (src != 5'd0);
  endfunction

  assign w_timeout_hit = (r_mstate == M_WAIT) && (r_wait_cnt == c_wait_last);
  assign w_fz          = mem_req & ~mem_ready & ~w_timeout_hit;
  assign w_ex_hit      = f_match(id_uses_rs1, id_rs1, r_ex) | f_match(id_uses_rs2, id_rs2, r_ex);

`ifdef FORWARDING_EN
  // ALU results are forwarded; only a load sitting in EX cannot be bypassed.
  assign w_hz = id_valid & w_ex_hit & r_ex.read_mem;
`else
  assign w_hz = id_valid & (w_ex_hit
                            | f_match(id_uses_rs1, id_rs1, r_mem)
                            | f_match(id_uses_rs2, id_rs2, r_mem));
`endif

  // A hazard on a wrong-path instruction is discarded by the redirect.
  assign w_stall = w_fz | (w_hz & ~ex_redirect);

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b1;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if (!rst_n) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_en    = 1'b0;
      id_ex_flush = 1'b1;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
    end else if (w_fz) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_hz) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    w_mstate_nxt = r_mstate;
    case (r_mstate)
      M_IDLE: if (mem_req && !mem_ready) w_mstate_nxt = M_WAIT;
      M_WAIT: if (mem_ready || !mem_req || w_timeout_hit) w_mstate_nxt = M_IDLE;
      default: w_mstate_nxt = M_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mstate   <= M_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_mstate <= w_mstate_nxt;
      if (r_mstate == M_WAIT) r_wait_cnt <= r_wait_cnt + c_tw'(1);
      else                    r_wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_error   <= 1'b0;
      r_stall_count <= '0;
    end else begin
      if (w_timeout_hit) r_mem_error <= 1'b1;
      if (w_stall && (r_stall_count != {CW{1'b1}})) r_stall_count <= r_stall_count + CW'(1);
    end
  end

  // Shadow scoreboard tracks what the ID/EX and EX/MEM registers hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex  <= '0;
      r_mem <= '0;
    end else if (!w_fz) begin
      r_mem <= r_ex;
      if (id_ex_flush) r_ex <= '0;
      else             r_ex <= '{valid: id_valid, rd: id_rd, write_reg: id_write_reg, read_mem: id_read_mem};
    end
  end

  assign mem_busy    = (r_mstate == M_WAIT);
  assign mem_error   = r_mem_error;
  assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipeline_sequencer: directed + random bench with a behavioural model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pipeline_sequencer;

  localparam int T  = 4;
  localparam int CW = 5;
`ifdef FORWARDING_EN
  localparam int c_alu_bubbles = 0;
  localparam int c_ld_bubbles  = 1;
`else
  localparam int c_alu_bubbles = 2;
  localparam int c_ld_bubbles  = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          id_valid, id_uses_rs1, id_uses_rs2, id_write_reg, id_read_mem;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          ex_redirect, mem_req, mem_ready;
  logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
  logic          mem_busy, mem_error;
  logic [CW-1:0] stall_count;

  pipeline_sequencer #(.MEM_TIMEOUT(T), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_write_reg(id_write_reg), .id_read_mem(id_read_mem), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en), .if_id_en(if_id_en),
    .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .mem_busy(mem_busy),
    .mem_error(mem_error), .stall_count(stall_count)
  );

  // Reference model: instructions in flight, memory wait status, counters.
  typedef struct {
    bit v;
    int rd;
    bit wr;
    bit ld;
  } instr_t;

  instr_t m_ex, m_mem;
  bit     m_busy, m_err;
  int     m_waited, m_stall;
  int     n_assert = 0, n_fail = 0;
  int     obs_stalls, obs_busy, obs_frozen;
  bit     last_pc_en, last_busy, last_frozen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hit(input int src, input bit used, input instr_t e);
    return used && e.v && e.wr && (e.rd == src) && (src != 0);
  endfunction

  function automatic bit model_hz();
    bit ex_dep, mem_dep;
    ex_dep  = hit(id_rs1, id_uses_rs1, m_ex)  || hit(id_rs2, id_uses_rs2, m_ex);
    mem_dep = hit(id_rs1, id_uses_rs1, m_mem) || hit(id_rs2, id_uses_rs2, m_mem);
`ifdef FORWARDING_EN
    return id_valid && ex_dep && m_ex.ld;
`else
    return id_valid && (ex_dep || mem_dep);
`endif
  endfunction

  function automatic bit model_fz();
    return mem_req && !mem_ready && !(m_busy && m_waited == T - 1);
  endfunction

  task automatic model_reset();
    m_ex = '{0, 0, 0, 0};
    m_mem = '{0, 0, 0, 0};
    m_busy = 0; m_err = 0; m_waited = 0; m_stall = 0;
  endtask

  task automatic check_all();
    logic [6:0] ctrl, exp;
    #1;
    ctrl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en};
    if (model_fz())           exp = 7'b0000000;
    else if (ex_redirect)     exp = 7'b1111111;
    else if (model_hz())      exp = 7'b0001111;
    else                      exp = 7'b1101011;
    check("ctrl", 32'(ctrl), 32'(exp));
    check("mem_busy", 32'(mem_busy), 32'(m_busy));
    check("mem_error", 32'(mem_error), 32'(m_err));
    check("stall_count", 32'(stall_count), 32'(m_stall));
    last_pc_en  = pc_en;
    last_busy   = mem_busy;
    last_frozen = (ctrl == 7'b0);
    if (pc_en === 1'b0) obs_stalls++;
    if (mem_busy === 1'b1) obs_busy++;
    if (ctrl == 7'b0) obs_frozen++;
  endtask

  task automatic advance();
    bit fz, hz;
    fz = model_fz();
    hz = model_hz();
    if ((fz || (hz && !ex_redirect)) && m_stall < (2 ** CW) - 1) m_stall++;
    if (!fz) begin
      m_mem = m_ex;
      if (ex_redirect || hz) m_ex = '{0, 0, 0, 0};
      else m_ex = '{id_valid, int'(id_rd), id_write_reg, id_read_mem};
    end
    if (!m_busy) begin
      if (mem_req && !mem_ready) begin m_busy = 1; m_waited = 0; end
    end else if (m_waited == T - 1) begin
      m_busy = 0; m_err = 1;
    end else if (mem_ready || !mem_req) begin
      m_busy = 0;
    end else begin
      m_waited++;
    end
  endtask

  task automatic tick();
    check_all();
    advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit wr, input bit ld);
    id_valid = v; id_rs1 = 5'(rs1); id_uses_rs1 = u1; id_rs2 = 5'(rs2); id_uses_rs2 = u2;
    id_rd = 5'(rd); id_write_reg = wr; id_read_mem = ld;
  endtask

  task automatic idle_inputs();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    ex_redirect = 0; mem_req = 0; mem_ready = 0;
  endtask

  // Producer writing x<rd> followed by a consumer of it; returns observed bubble count.
  task automatic dep_pair(input int rd, input bit ld, output int bubbles);
    set_id(1, 1, 1, 0, 0, rd, 1, ld);
    tick();
    obs_stalls = 0;
    set_id(1, rd, 1, 1, 1, 6, 1, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (last_pc_en) break;
    end
    bubbles = obs_stalls;
    idle_inputs();
    tick(); tick();
  endtask

  initial begin
    int b, stall_before;
    bit released;
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #3;
    check("rst_ctrl", 32'({pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}), 32'h14);
    check("rst_stall", 32'(stall_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    dep_pair(5, 0, b);
    check("alu_use_bubbles", 32'(b), 32'(c_alu_bubbles));
    dep_pair(5, 1, b);
    check("load_use_bubbles", 32'(b), 32'(c_ld_bubbles));
    dep_pair(0, 1, b);
    check("x0_no_stall", 32'(b), 32'd0);

    // Taken branch in EX while ID has a hazard.
    set_id(1, 1, 1, 0, 0, 5, 1, 1);
    tick();
    stall_before = m_stall;
    set_id(1, 5, 1, 5, 1, 7, 1, 0);
    ex_redirect = 1;
    tick();
    check("redirect_stall_same", 32'(stall_count), 32'(stall_before));
    idle_inputs();
    tick(); tick();

    // Slow memory: ready low for 3 cycles.
    stall_before = m_stall;
    obs_busy = 0; obs_frozen = 0;
    mem_req = 1; mem_ready = 0;
    repeat (3) tick();
    mem_ready = 1;
    tick();
    mem_req = 0; mem_ready = 0;
    tick();
    check("slow_frozen", 32'(obs_frozen), 32'd3);
    check("slow_busy", 32'(obs_busy), 32'd3);
    check("slow_stall", 32'(stall_count), 32'(stall_before + 3));

    // Timeout: ready stuck low.
    obs_busy = 0; obs_frozen = 0;
    released = 0;
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (last_busy && !last_frozen) begin released = 1; break; end
    end
    check("timeout_released", 32'(released), 32'd1);
    check("timeout_busy_frozen", 32'(obs_frozen - 1), 32'd3);
    check("timeout_error", 32'(mem_error), 32'd1);
    mem_req = 0;
    tick();

    // Asynchronous reset in the middle of an access.
    mem_req = 1; mem_ready = 0;
    tick();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_ctrl", 32'({pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}), 32'h14);
    check("arst_busy", 32'(mem_busy), 32'd0);
    check("arst_error", 32'(mem_error), 32'd0);
    check("arst_stall", 32'(stall_count), 32'd0);
    mem_req = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 600; i++) begin
      set_id(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      ex_redirect = ($urandom_range(0, 7) == 0);
      mem_req     = ($urandom_range(0, 2) == 0) || (m_busy && $urandom_range(0, 5) != 0);
      mem_ready   = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
